// File: rtl/model_dnc_pkg.sv
// model_dnc_pkg: shared DNC interface-parser types and fixed-point conditioning helpers.
package model_dnc_pkg;
    typedef enum logic [2:0] {IDLE, KEY, BETA, ERASE, WVEC, GA, GW, DONE} state_t;
    typedef logic signed [63:0] word_t;
    localparam int DNC_FRACTION = 32;
    localparam word_t ONE = word_t'(1) << DNC_FRACTION;
    localparam word_t MAX_POS = {1'b0, {63{1'b1}}};

    function automatic word_t clamp(input word_t x, input word_t one);
        return (x < 0) ? '0 : (x > one) ? one : x;
    endfunction

    // Comparing against MAX_POS - one first keeps the addition from ever overflowing.
    function automatic word_t oneplus(input word_t x, input word_t one);
        return (x <= 0) ? one : (x > MAX_POS - one) ? MAX_POS : one + x;
    endfunction
endpackage

// File: rtl/model_write_heads_condition.sv
// model_write_heads_condition: routes one accepted word to its field, conditions it,
// and registers the per-field streams together with the head index.
module model_write_heads_condition
    import model_dnc_pkg::*;
#(
    parameter int DATA_SIZE = 64,
    parameter int FRACTION = 32,
    parameter int HW = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  state_t               field,
    input  logic [HW-1:0]        head,
    input  logic [DATA_SIZE-1:0] x,
    output logic [HW-1:0]        head_q,
    output logic                 k_en,
    output logic                 beta_en,
    output logic                 e_en,
    output logic                 v_en,
    output logic                 ga_en,
    output logic                 gw_en,
    output logic [DATA_SIZE-1:0] k,
    output logic [DATA_SIZE-1:0] beta,
    output logic [DATA_SIZE-1:0] e,
    output logic [DATA_SIZE-1:0] v,
    output logic [DATA_SIZE-1:0] ga,
    output logic [DATA_SIZE-1:0] gw
);
    localparam word_t ONE_P = word_t'(1) << FRACTION;

    logic [DATA_SIZE-1:0] y;
    logic [5:0]           sel;

    always_comb begin
        y = (field == BETA) ? oneplus(x, ONE_P) : (field == KEY || field == WVEC) ? x : clamp(x, ONE_P);
        sel = en ? {field == GW, field == GA, field == WVEC, field == ERASE, field == BETA, field == KEY} : 6'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q <= '0;
            {gw_en, ga_en, v_en, e_en, beta_en, k_en} <= '0;
            k <= '0;
            beta <= '0;
            e <= '0;
            v <= '0;
            ga <= '0;
            gw <= '0;
        end else begin
            {gw_en, ga_en, v_en, e_en, beta_en, k_en} <= sel;
            if (en) head_q <= head;
            if (sel[0]) k <= y;
            if (sel[1]) beta <= y;
            if (sel[2]) e <= y;
            if (sel[3]) v <= y;
            if (sel[4]) ga <= y;
            if (sel[5]) gw <= y;
        end
    end
endmodule

// File: rtl/model_write_heads_parser.sv
// model_write_heads_parser: parses the H-head DNC write-interface stream into
// conditioned key/strength/erase/vector/gate streams tagged with their head index.
module model_write_heads_parser
    import model_dnc_pkg::*;
#(
    parameter int DATA_SIZE = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int H = 4,
    parameter int W_MAX = 64,
    parameter int FRACTION = 32
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            START,
    output logic                            READY,
    output logic                            BUSY,
    input  logic [CONTROL_SIZE-1:0]         SIZE_W_IN,
    input  logic                            XI_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]            XI_IN,
    output logic [((H > 1) ? $clog2(H) : 1)-1:0] HEAD_OUT,
    output logic                            K_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]            K_OUT,
    output logic                            BETA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]            BETA_OUT,
    output logic                            E_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]            E_OUT,
    output logic                            V_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]            V_OUT,
    output logic                            GA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]            GA_OUT,
    output logic                            GW_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]            GW_OUT
);
    localparam int HW = (H > 1) ? $clog2(H) : 1;

    state_t                  state, next, first;
    logic [CONTROL_SIZE-1:0] wl, wl_in, word;
    logic [HW-1:0]           head;
    logic                    accept, last;

    always_comb begin
        wl_in = (SIZE_W_IN > CONTROL_SIZE'(W_MAX)) ? CONTROL_SIZE'(W_MAX) : SIZE_W_IN;
        accept = XI_IN_ENABLE && state != IDLE && state != DONE;
        last = word == wl - 1'b1;
        first = (wl == '0) ? BETA : KEY;
        next = state;
        case (state)
            IDLE:    next = START ? ((wl_in == '0) ? BETA : KEY) : IDLE;
            KEY:     next = (accept && last) ? BETA : KEY;
            BETA:    next = accept ? ((wl == '0) ? GA : ERASE) : BETA;
            ERASE:   next = (accept && last) ? WVEC : ERASE;
            WVEC:    next = (accept && last) ? GA : WVEC;
            GA:      next = accept ? GW : GA;
            GW:      next = accept ? ((head == HW'(H - 1)) ? DONE : first) : GW;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            wl <= '0;
            word <= '0;
            head <= '0;
        end else begin
            state <= next;
            if (state == IDLE && START) begin
                wl <= wl_in;
                word <= '0;
                head <= '0;
            end else if (accept && (state == KEY || state == ERASE || state == WVEC)) begin
                word <= last ? '0 : word + 1'b1;
            end
            if (accept && state == GW && head != HW'(H - 1)) head <= head + 1'b1;
        end
    end

    assign READY = state == DONE;
    assign BUSY = state != IDLE && state != DONE;

    model_write_heads_condition #(.DATA_SIZE(DATA_SIZE), .FRACTION(FRACTION), .HW(HW)) u_cond (
        .clk(CLK), .rst(RST), .en(accept), .field(state), .head(head), .x(XI_IN),
        .head_q(HEAD_OUT),
        .k_en(K_OUT_ENABLE), .beta_en(BETA_OUT_ENABLE), .e_en(E_OUT_ENABLE),
        .v_en(V_OUT_ENABLE), .ga_en(GA_OUT_ENABLE), .gw_en(GW_OUT_ENABLE),
        .k(K_OUT), .beta(BETA_OUT), .e(E_OUT), .v(V_OUT), .ga(GA_OUT), .gw(GW_OUT)
    );
endmodule

// File: tb/tb_model_write_heads_parser.sv
// tb_model_write_heads_parser: directed stimulus with a queue-based scoreboard and
// an independent output monitor for the H=2 write-heads parser.
module tb_model_write_heads_parser;
    localparam logic signed [63:0] ONE = 64'sh1_0000_0000;
    localparam logic signed [63:0] MAXP = 64'sh7FFF_FFFF_FFFF_FFFF;

    typedef struct {
        int f;
        int h;
        logic [63:0] d;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST, START, XI_IN_ENABLE;
    logic [63:0] SIZE_W_IN, XI_IN;
    logic        READY, BUSY;
    logic [0:0]  HEAD_OUT;
    logic        K_OUT_ENABLE, BETA_OUT_ENABLE, E_OUT_ENABLE, V_OUT_ENABLE, GA_OUT_ENABLE, GW_OUT_ENABLE;
    logic [63:0] K_OUT, BETA_OUT, E_OUT, V_OUT, GA_OUT, GW_OUT;

    exp_t        exp_q[$];
    logic [63:0] stim[$];
    logic [63:0] want[$];
    logic [63:0] last_d[6];
    logic        rst_q;
    int          total = 0, bad = 0, ready_issued = 0, ready_seen = 0;

    model_write_heads_parser #(.DATA_SIZE(64), .CONTROL_SIZE(64), .H(2), .W_MAX(64), .FRACTION(32)) dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY), .BUSY(BUSY),
        .SIZE_W_IN(SIZE_W_IN), .XI_IN_ENABLE(XI_IN_ENABLE), .XI_IN(XI_IN), .HEAD_OUT(HEAD_OUT),
        .K_OUT_ENABLE(K_OUT_ENABLE), .K_OUT(K_OUT), .BETA_OUT_ENABLE(BETA_OUT_ENABLE), .BETA_OUT(BETA_OUT),
        .E_OUT_ENABLE(E_OUT_ENABLE), .E_OUT(E_OUT), .V_OUT_ENABLE(V_OUT_ENABLE), .V_OUT(V_OUT),
        .GA_OUT_ENABLE(GA_OUT_ENABLE), .GA_OUT(GA_OUT), .GW_OUT_ENABLE(GW_OUT_ENABLE), .GW_OUT(GW_OUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] model(input int f, input logic signed [63:0] x);
        if (f == 0 || f == 3) return x;
        if (f == 1) return (x <= 0) ? ONE : (x > MAXP - ONE) ? MAXP : ONE + x;
        return (x < 0) ? 64'd0 : (x > ONE) ? ONE : x;
    endfunction

    function automatic int fld(input int j, input int wl);
        return (j < wl) ? 0 : (j == wl) ? 1 : (j <= 2 * wl) ? 2 : (j <= 3 * wl) ? 3 : (j == 3 * wl + 1) ? 4 : 5;
    endfunction

    always @(posedge CLK) rst_q <= RST;

    always @(negedge CLK) begin
        logic [5:0]  en;
        logic [63:0] dv[6];
        exp_t        e;
        int          f;
        logic        held;
        en = {GW_OUT_ENABLE, GA_OUT_ENABLE, V_OUT_ENABLE, E_OUT_ENABLE, BETA_OUT_ENABLE, K_OUT_ENABLE};
        dv = '{K_OUT, BETA_OUT, E_OUT, V_OUT, GA_OUT, GW_OUT};
        if (rst_q !== 1'b1) begin
            for (int i = 0; i < 6; i++) last_d[i] = '0;
        end else begin
            f = 0;
            for (int i = 0; i < 6; i++) if (en[i]) f = i;
            if (en != 0) begin
                total++;
                if ($countones(en) != 1 || exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_word: enables=%b queued=%0d, required exactly one enable and a queued word", en, exp_q.size());
                end else begin
                    e = exp_q.pop_front();
                    if (f != e.f || int'(HEAD_OUT) != e.h || dv[f] != e.d) begin
                        bad++;
                        $display("FAIL out_word: got field=%0d head=%0d data=%h, required field=%0d head=%0d data=%h",
                                 f, HEAD_OUT, dv[f], e.f, e.h, e.d);
                    end
                end
            end
            held = 1'b1;
            for (int i = 0; i < 6; i++) if (!en[i] && dv[i] != last_d[i]) held = 1'b0;
            total++;
            if (!held) begin
                bad++;
                $display("FAIL hold: enables=%b outputs changed without their enable", en);
            end
            for (int i = 0; i < 6; i++) if (en[i]) last_d[i] = dv[i];
            if (READY) begin
                total++;
                ready_seen++;
                if (ready_seen > ready_issued || !GW_OUT_ENABLE) begin
                    bad++;
                    $display("FAIL ready: seen=%0d issued=%0d gw_en=%b, required READY alongside the last gw word", ready_seen, ready_issued, GW_OUT_ENABLE);
                end
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_word(input int idx, input int j, input int wl, input int h);
        exp_t e;
        e.f = fld(j, wl);
        e.h = h;
        e.d = (want.size() != 0) ? want.pop_front() : model(e.f, stim[idx]);
        exp_q.push_back(e);
        XI_IN_ENABLE = 1'b1;
        XI_IN = stim[idx];
    endtask

    task automatic run_parse(input int w_in, input int gap, input bit poke);
        int wl, idx, n;
        wl = (w_in > 64) ? 64 : w_in;
        SIZE_W_IN = 64'(w_in);
        START = 1'b1;
        tick;
        START = 1'b0;
        total++;
        if (BUSY !== 1'b1) begin
            bad++;
            $display("FAIL busy_start: BUSY=%b, required 1", BUSY);
        end
        idx = 0;
        for (int h = 0; h < 2; h++) begin
            for (int j = 0; j < 3 * wl + 3; j++) begin
                while ($urandom_range(99) < gap) begin
                    XI_IN_ENABLE = 1'b0;
                    XI_IN = {$urandom, $urandom};
                    tick;
                end
                drive_word(idx, j, wl, h);
                START = poke && idx == 3;
                if (h == 1 && j == 3 * wl + 2) ready_issued++;
                idx++;
                tick;
                START = 1'b0;
            end
        end
        XI_IN_ENABLE = 1'b0;
        START = poke;
        tick;
        START = 1'b0;
        n = 0;
        while (BUSY && n < 4) begin
            tick;
            n++;
        end
        total++;
        if (BUSY !== 1'b0) begin
            bad++;
            $display("FAIL busy_end: BUSY=%b, required 0 after READY", BUSY);
        end
    endtask

    task automatic fill_count(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(64'(i + 1) << 32);
    endtask

    initial begin
        RST = 1'b0;
        START = 1'b0;
        XI_IN_ENABLE = 1'b0;
        XI_IN = '0;
        SIZE_W_IN = '0;
        repeat (3) tick;
        total++;
        if (READY || BUSY || HEAD_OUT != 0 ||
            {K_OUT_ENABLE, BETA_OUT_ENABLE, E_OUT_ENABLE, V_OUT_ENABLE, GA_OUT_ENABLE, GW_OUT_ENABLE} != 0 ||
            (K_OUT | BETA_OUT | E_OUT | V_OUT | GA_OUT | GW_OUT) != 0) begin
            bad++;
            $display("FAIL reset_state: READY=%b BUSY=%b HEAD=%0d, required all outputs 0", READY, BUSY, HEAD_OUT);
        end
        RST = 1'b1;
        tick;

        fill_count(18);
        run_parse(2, 0, 1'b0);

        stim = '{64'h1_0000_0000, 64'h2_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFD,
                 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFB, 64'h2_0000_0000,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h7FFF_FFFF_0000_0000, 64'h1_8000_0000, 64'h1_0000_0000,
                 64'h0, 64'h1_0000_0000, 64'h1_0000_0000, 64'h0};
        want = '{64'h1_0000_0000, 64'h2_0000_0000, 64'h1_0000_0000, 64'h8000_0000, 64'h0,
                 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 64'h1_0000_0000,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 64'h1_0000_0000,
                 64'h0, 64'h1_0000_0000, 64'h1_0000_0000, 64'h0};
        run_parse(2, 0, 1'b0);

        stim = '{64'h3_0000_0000, 64'h4000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h5_0000_0000, 64'h1};
        want = '{64'h4_0000_0000, 64'h4000_0000, 64'h0, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1};
        run_parse(0, 0, 1'b0);

        fill_count(390);
        run_parse(1000, 0, 1'b0);

        fill_count(18);
        run_parse(2, 50, 1'b1);

        fill_count(18);
        SIZE_W_IN = 64'd2;
        START = 1'b1;
        tick;
        START = 1'b0;
        for (int i = 0; i < 13; i++) begin
            drive_word(i, i % 9, 2, i / 9);
            tick;
        end
        RST = 1'b0;
        XI_IN_ENABLE = 1'b1;
        XI_IN = stim[13];
        tick;
        total++;
        if (READY || BUSY || HEAD_OUT != 0 || exp_q.size() != 0 ||
            {K_OUT_ENABLE, BETA_OUT_ENABLE, E_OUT_ENABLE, V_OUT_ENABLE, GA_OUT_ENABLE, GW_OUT_ENABLE} != 0 ||
            (K_OUT | BETA_OUT | E_OUT | V_OUT | GA_OUT | GW_OUT) != 0) begin
            bad++;
            $display("FAIL mid_reset: READY=%b BUSY=%b HEAD=%0d E_OUT=%h queued=%0d, required all 0", READY, BUSY, HEAD_OUT, E_OUT, exp_q.size());
        end
        RST = 1'b1;
        XI_IN_ENABLE = 1'b0;
        tick;

        fill_count(18);
        run_parse(2, 0, 1'b0);

        repeat (4) tick;
        total++;
        if (exp_q.size() != 0 || ready_seen != ready_issued) begin
            bad++;
            $display("FAIL drain: queued=%0d ready_seen=%0d, required 0 queued and ready_seen=%0d", exp_q.size(), ready_seen, ready_issued);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
